// File: rtl/uart_pkg.sv
// Shared state encoding, default bit divider and counter-width helper for the UART core.
package uart_pkg;

    localparam int BIT_DIV_DEFAULT = 10417;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit-period timer: load a value, count down while enabled, flag expiry at zero.
module uart_bit_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Holds at zero rather than wrapping; the owning FSM reloads on every state change.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with valid/ready TX and RX, mid-bit RX sampling, framing and overrun flags.
// Define UART_PARITY_EN to add one parity bit per frame (even, or odd with PARITY_ODD=1).
module uart_core
    import uart_pkg::*;
#(
    parameter int BIT_DIV    = BIT_DIV_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);

    localparam int CNT_W = cnt_w(BIT_DIV);
    localparam int IDX_W = cnt_w(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(BIT_DIV * STOP_BITS - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_DIV / 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam logic             PAR_EN    = 1'b1;
`else
    localparam logic             PAR_EN    = 1'b0;
`endif

    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_bit_q, tx_bit_d;
    logic                 tx_load, tx_expire;
    logic [CNT_W-1:0]     tx_load_val;

    uart_bit_timer #(.W(CNT_W)) u_tx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (tx_load_val),
        .en_i       (tx_state_q != S_IDLE),
        .expire_o   (tx_expire)
    );

    // tx_bit_d is the line level for the state being entered, so tx is registered and glitch-free.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_idx_d    = tx_idx_q;
        tx_par_d    = tx_par_q;
        tx_bit_d    = tx_bit_q;
        tx_load     = 1'b0;
        tx_load_val = BIT_LOAD;
        case (tx_state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = S_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_INV;
                    tx_bit_d   = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            S_START: begin
                if (tx_expire) begin
                    tx_state_d = S_DATA;
                    tx_idx_d   = '0;
                    tx_bit_d   = tx_shift_q[0];
                    tx_load    = 1'b1;
                end
            end
            S_DATA: begin
                if (tx_expire) begin
                    tx_load = 1'b1;
                    if (tx_idx_q == LAST_IDX) begin
                        if (PAR_EN) begin
                            tx_state_d = S_PARITY;
                            tx_bit_d   = tx_par_q;
                        end else begin
                            tx_state_d  = S_STOP;
                            tx_bit_d    = 1'b1;
                            tx_load_val = STOP_LOAD;
                        end
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_expire) begin
                    tx_state_d  = S_STOP;
                    tx_bit_d    = 1'b1;
                    tx_load     = 1'b1;
                    tx_load_val = STOP_LOAD;
                end
            end
            S_STOP: begin
                if (tx_expire) begin
                    tx_state_d = S_IDLE;
                    tx_bit_d   = 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_bit_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_idx_q   <= '0;
            tx_bit_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_bit_q   <= tx_bit_d;
        end
        tx_shift_q <= tx_shift_d;
        tx_par_q   <= tx_par_d;
    end

    assign tx_ready = (tx_state_q == S_IDLE);
    assign tx       = tx_bit_q;

    logic                 rx_s1_q, rx_s2_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_load, rx_expire;
    logic [CNT_W-1:0]     rx_load_val;

    uart_bit_timer #(.W(CNT_W)) u_rx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .en_i       (rx_state_q != S_IDLE),
        .expire_o   (rx_expire)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_idx_d    = rx_idx_q;
        rx_par_d    = rx_par_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        rx_ferr_d   = 1'b0;
        rx_ovr_d    = 1'b0;
        rx_perr_d   = 1'b0;
        rx_load     = 1'b0;
        rx_load_val = BIT_LOAD;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d  = S_START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_LOAD;
                end
            end
            S_START: begin
                if (rx_expire) begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_idx_d   = '0;
                        rx_load    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_expire) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_idx_q == LAST_IDX) begin
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_expire) begin
                    rx_par_d   = rx_s2_q;
                    rx_state_d = S_STOP;
                    rx_load    = 1'b1;
                end
            end
            S_STOP: begin
                // Return to IDLE at the mid-stop sample so the next start edge is caught.
                if (rx_expire) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q) begin
                        rx_ferr_d = 1'b1;
                    end else if (PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_INV))) begin
                        rx_perr_d = 1'b1;
                    end else if (rx_valid_q && !rx_ready) begin
                        rx_ovr_d = 1'b1;
                    end else begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_idx_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_perr_q  <= rx_perr_d;
        end
        rx_shift_q <= rx_shift_d;
        rx_par_q   <= rx_par_d;
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;
    assign rx_parity_err = PAR_EN ? rx_perr_q : 1'b0;

endmodule
